mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port valid_i, input, 1 bit: execute result present this cycle.
REQ-004 SHALL have port opcode_i, input, 5 bits: instruction opcode from execute.
REQ-005 SHALL have port exeOut_i, input, 32 bits: ALU result, which is the load/store address for memory ops.
REQ-006 SHALL have port RegData1_i, input, 32 bits: store data.
REQ-007 SHALL have port stall_o, output, 1 bit: high means upstream must hold and valid_i is ignored.
REQ-008 SHALL have port dmem_req, output, 1 bit: data-memory request, held until ack.
REQ-009 SHALL have port dmem_we, output, 1 bit: 1 = write.
REQ-010 SHALL have port dmem_addr, output, 32 bits: word-aligned address.
REQ-011 SHALL have port dmem_wdata, output, 32 bits: write data.
REQ-012 SHALL have port dmem_ack, input, 1 bit: memory completion, one-cycle pulse.
REQ-013 SHALL have port dmem_rdata, input, 32 bits: read data, valid only with dmem_ack.
REQ-014 SHALL have port valid_o, output, 1 bit: one-cycle pulse when a result is issued to writeback.
REQ-015 SHALL have port wbData_o, output, 32 bits: writeback value.
REQ-016 SHALL have port opcode_o, output, 5 bits: opcode of the issued result.
REQ-017 SHALL have port err_o, output, 1 bit: one-cycle pulse with valid_o on misalignment or timeout.
REQ-018 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles before abort.

Function
REQ-019 SHALL classify opcodes as: LD 5'h0D and POP 5'h10 are loads; ST 5'h0E and PUSH 5'h0F are stores; all other opcodes are non-memory.
REQ-020 SHALL implement states IDLE and BUSY; stall_o = (state==BUSY).
REQ-021 In IDLE, a non-memory op with valid_i SHALL produce valid_o=1, wbData_o=exeOut_i and opcode_o=opcode_i on the next cycle (1-cycle latency).
REQ-022 In IDLE, an aligned memory op (exeOut_i[1:0]==0) with valid_i SHALL latch address, data, opcode and we, then enter BUSY.
REQ-023 While in BUSY, dmem_req SHALL be 1, with dmem_addr, dmem_we and dmem_wdata stable from the latched values.
REQ-024 In IDLE, a misaligned memory op SHALL issue no dmem_req and SHALL produce valid_o=1, err_o=1, wbData_o=0 on the next cycle.
REQ-025 On dmem_ack sampled in BUSY, the next cycle SHALL be IDLE with dmem_req=0 and valid_o=1; wbData_o = dmem_rdata for loads and the latched store data for stores.
REQ-026 The minimum memory-op latency, from accept to valid_o, SHALL be 2 cycles.
REQ-027 SHALL keep an 8-bit wait counter, cleared on entering BUSY and incremented each BUSY cycle without ack.
REQ-028 When the counter reaches TIMEOUT with no ack, the block SHALL return to IDLE and issue valid_o=1, err_o=1, wbData_o=32'hDEAD_BEEF.
REQ-029 If dmem_ack and the timeout occur in the same cycle, ack SHALL win and err_o SHALL be 0.
REQ-030 dmem_ack in IDLE SHALL be ignored.
REQ-031 valid_i while stall_o=1 SHALL be ignored.
REQ-032 valid_o SHALL never assert for two consecutive cycles from one instruction.

Reset
REQ-033 Asserting rst SHALL immediately force state IDLE and dmem_req, dmem_we, valid_o, err_o, stall_o, counter = 0.
REQ-034 Asserting rst SHALL immediately force dmem_addr, dmem_wdata, wbData_o = 0 and opcode_o = 5'h00.
REQ-035 rst during BUSY SHALL abandon the access with no valid_o issued; a later dmem_ack for it SHALL be ignored.

Structure
REQ-036 Opcode constants (LD, ST, PUSH, POP) and the timeout poison value SHALL live in the shared cpu package used by decode and execute.
REQ-037 A single sub-module, mem_timeout_cnt (8-bit clear/enable/terminal-count), is natural; everything else SHALL be flat.

Verification
REQ-038 Non-memory op: opcode 5'h00, exeOut_i=3 -> next cycle valid_o=1, wbData_o=3, no dmem_req.
REQ-039 Aligned load: opcode 5'h10, exeOut_i=0x100, ack after 3 cycles with rdata=0xCAFE -> dmem_req held 3 cycles, dmem_we=0, valid_o with wbData_o=0xCAFE, stall_o high throughout.
REQ-040 PUSH: opcode 5'h0F, exeOut_i=4, RegData1_i=2, ack in the first BUSY cycle -> dmem_we=1, dmem_addr=4, dmem_wdata=2, valid_o 2 cycles after accept.
REQ-041 Misaligned: opcode 5'h0D, exeOut_i=0x102 -> no dmem_req; next cycle valid_o=1, err_o=1, wbData_o=0.
REQ-042 Timeout: load with no ack -> after 255 BUSY cycles valid_o=1, err_o=1, wbData_o=32'hDEAD_BEEF; repeat with ack on cycle 255 -> err_o=0.
REQ-043 Reset mid-BUSY: assert rst during a load -> dmem_req drops immediately; ack after deassertion produces no valid_o.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared CPU constants for the memory stage: memory opcodes, the timeout
// poison value, FSM state encodings and opcode classification helpers.
package mem_stage_pkg;

  localparam logic [4:0] OP_LD   = 5'h0D;
  localparam logic [4:0] OP_ST   = 5'h0E;
  localparam logic [4:0] OP_PUSH = 5'h0F;
  localparam logic [4:0] OP_POP  = 5'h10;

  localparam logic [31:0] TIMEOUT_POISON = 32'hDEAD_BEEF;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  function automatic logic is_load(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_POP);
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return (op == OP_ST) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// 8-bit wait counter with synchronous clear, count enable and a
// terminal-count flag raised while the count equals TERM.
module mem_timeout_cnt #(
  parameter logic [7:0] TERM = 8'd254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes non-memory results through in one cycle and
// runs one blocking data-memory access at a time for loads and stores.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  opcode_i,
  input  logic [31:0] exeOut_i,
  input  logic [31:0] RegData1_i,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_o,
  output logic [31:0] wbData_o,
  output logic [4:0]  opcode_o,
  output logic        err_o
);

  // The timeout fires on the BUSY cycle that would bring the count to TIMEOUT.
  localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [4:0] op_q;
  logic       busy;
  logic       is_mem;
  logic       aligned;
  logic       cnt_tc;

  // Memory handshake: dmem_req stays high with addr/we/wdata frozen for the
  // whole BUSY period; a one-cycle dmem_ack completes it (rdata valid only then).
  // stall_o is the FSM state bit, so it doubles as the state debug view.
  assign busy     = (state == S_BUSY);
  assign stall_o  = busy;
  assign dmem_req = busy;
  assign is_mem   = is_load(opcode_i) || is_store(opcode_i);
  assign aligned  = (exeOut_i[1:0] == 2'b00);

  mem_timeout_cnt #(.TERM(TERM)) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!busy),
    .en  (busy && !dmem_ack),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= 5'h00;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      wbData_o   <= 32'h0;
      opcode_o   <= 5'h00;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o  <= 1'b1;
              wbData_o <= exeOut_i;
              opcode_o <= opcode_i;
            end else if (!aligned) begin
              valid_o  <= 1'b1;
              err_o    <= 1'b1;
              wbData_o <= 32'h0;
              opcode_o <= opcode_i;
            end else begin
              state      <= S_BUSY;
              op_q       <= opcode_i;
              dmem_we    <= is_store(opcode_i);
              dmem_addr  <= exeOut_i;
              dmem_wdata <= RegData1_i;
            end
          end
        end
        default: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (dmem_ack) begin
            state    <= S_IDLE;
            valid_o  <= 1'b1;
            wbData_o <= dmem_we ? dmem_wdata : dmem_rdata;
            opcode_o <= op_q;
          end else if (cnt_tc) begin
            state    <= S_IDLE;
            valid_o  <= 1'b1;
            err_o    <= 1'b1;
            wbData_o <= TIMEOUT_POISON;
            opcode_o <= op_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written reset/idle-ack and
// timeout sequences, then random operations checked against a rule-level model.
module tb_mem_stage;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  opcode_i;
  logic [31:0] exeOut_i;
  logic [31:0] RegData1_i;
  logic        stall_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_o;
  logic [31:0] wbData_o;
  logic [4:0]  opcode_o;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_wb;
  } vec_t;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .opcode_i   (opcode_i),
    .exeOut_i   (exeOut_i),
    .RegData1_i (RegData1_i),
    .stall_o    (stall_o),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .valid_o    (valid_o),
    .wbData_o   (wbData_o),
    .opcode_o   (opcode_o),
    .err_o      (err_o)
  );

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- helpers / reference model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic op_is_load(input logic [4:0] op);
    return (op == 5'h0D) || (op == 5'h10);
  endfunction

  function automatic logic op_is_store(input logic [4:0] op);
    return (op == 5'h0E) || (op == 5'h0F);
  endfunction

  // Result of one instruction from the stage's rules: {err, writeback value}.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [31:0] rdata,
                                        input int delay);
    if (!(op_is_load(op) || op_is_store(op))) return {1'b0, addr};
    if (addr[1:0] != 2'b00) return {1'b1, 32'h0};
    if (delay >= TIMEOUT) return {1'b1, 32'hDEAD_BEEF};
    if (op_is_store(op)) return {1'b0, data};
    return {1'b0, rdata};
  endfunction

  // ---------------- driver ----------------
  // delay = BUSY cycles before the ack cycle; delay >= TIMEOUT means no ack.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input int delay, input logic [31:0] rdata,
                        input logic exp_err, input logic [31:0] exp_wb);
    logic mem;
    int   waits;
    mem = (op_is_load(op) || op_is_store(op)) && (addr[1:0] == 2'b00);
    exp_q.push_back(exp_wb);
    check({name, "_idle_stall"}, 32'(stall_o), 32'd0);
    opcode_i   = op;
    exeOut_i   = addr;
    RegData1_i = data;
    valid_i    = 1'b1;
    tick;
    valid_i    = 1'b0;
    exeOut_i   = $urandom;
    RegData1_i = $urandom;
    if (mem) begin
      check({name, "_req_flags"}, {29'd0, dmem_req, stall_o, dmem_we}, {29'd0, 2'b11, op_is_store(op)});
      check({name, "_addr"}, dmem_addr, addr);
      check({name, "_wdata"}, dmem_wdata, data);
      waits = (delay < TIMEOUT) ? delay : TIMEOUT;
      for (int k = 0; k < waits; k++) begin
        check({name, "_busy_flags"}, {29'd0, dmem_req, stall_o, valid_o}, {29'd0, 3'b110});
        check({name, "_busy_addr"}, dmem_addr, addr);
        valid_i  = 1'($urandom_range(0, 1));
        opcode_i = 5'h01;
        tick;
      end
      if (delay < TIMEOUT) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
      valid_i = 1'b0;
    end else begin
      check({name, "_no_req"}, 32'(dmem_req), 32'd0);
    end
    check({name, "_valid"}, 32'(valid_o), 32'd1);
    check({name, "_err"}, 32'(err_o), 32'(exp_err));
    check({name, "_opcode"}, 32'(opcode_o), 32'(op));
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      check({name, "_wb"}, wbData_o, exp_q.pop_front());
    end
    check({name, "_post_req"}, {30'd0, dmem_req, stall_o}, 32'd0);
    tick;
    check({name, "_single_valid"}, 32'(valid_o), 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[11];

  initial begin
    logic [4:0]  r_op;
    logic [31:0] r_addr, r_data, r_rdata;
    int          r_delay;
    logic [32:0] r_exp;
    logic [4:0]  op_pool[10];

    vecs[0]  = '{"nonmem",        5'h00, 32'h3,         32'h0,         0, 32'h0,         1'b0, 32'h3};
    vecs[1]  = '{"pop_load",      5'h10, 32'h100,       32'h5555,      2, 32'hCAFE,      1'b0, 32'hCAFE};
    vecs[2]  = '{"push",          5'h0F, 32'h4,         32'h2,         0, 32'h9999,      1'b0, 32'h2};
    vecs[3]  = '{"misalign_ld",   5'h0D, 32'h102,       32'h0,         0, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{"store",         5'h0E, 32'h200,       32'h1234_5678, 1, 32'hFFFF_0000, 1'b0, 32'h1234_5678};
    vecs[5]  = '{"ld",            5'h0D, 32'h40,        32'h0,         4, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A};
    vecs[6]  = '{"misalign_st",   5'h0E, 32'h201,       32'h77,        0, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{"misalign_push", 5'h0F, 32'h3,         32'h77,        0, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{"nonmem_1f",     5'h1F, 32'hFFFF_FFFF, 32'h0,         0, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vecs[9]  = '{"nonmem_0c",     5'h0C, 32'h102,       32'h0,         0, 32'h0,         1'b0, 32'h102};
    vecs[10] = '{"nonmem_11",     5'h11, 32'h7,         32'h0,         0, 32'h0,         1'b0, 32'h7};

    rst = 1'b1;
    valid_i = 1'b0;
    opcode_i = 5'h00;
    exeOut_i = 32'h0;
    RegData1_i = 32'h0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    check("reset_flags", {27'd0, stall_o, dmem_req, dmem_we, valid_o, err_o}, 32'd0);
    check("reset_addr", dmem_addr, 32'h0);
    check("reset_wdata", dmem_wdata, 32'h0);
    check("reset_wb", wbData_o, 32'h0);
    check("reset_opcode", 32'(opcode_o), 32'h0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].delay,
             vecs[i].rdata, vecs[i].exp_err, vecs[i].exp_wb);

    // Ack while idle must not produce a result.
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111;
    tick;
    dmem_ack = 1'b0;
    check("idle_ack_valid", {30'd0, valid_o, stall_o}, 32'd0);
    tick;

    // Timeout with no ack, then ack exactly on the last allowed BUSY cycle.
    run_op("timeout", 5'h0D, 32'h80, 32'h0, TIMEOUT, 32'h0, 1'b1, 32'hDEAD_BEEF);
    run_op("ack_at_limit", 5'h10, 32'h84, 32'h0, TIMEOUT - 1, 32'h1234, 1'b0, 32'h1234);

    // Reset in the middle of a load; the late ack is ignored.
    opcode_i = 5'h10;
    exeOut_i = 32'h300;
    valid_i = 1'b1;
    tick;
    valid_i = 1'b0;
    check("mid_rst_busy", {30'd0, dmem_req, stall_o}, 32'd3);
    tick;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {27'd0, stall_o, dmem_req, dmem_we, valid_o, err_o}, 32'd0);
    check("mid_rst_addr", dmem_addr, 32'h0);
    tick;
    rst = 1'b0;
    tick;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0;
    tick;
    dmem_ack = 1'b0;
    check("mid_rst_late_ack", {30'd0, valid_o, stall_o}, 32'd0);
    tick;
    check("mid_rst_quiet", {30'd0, valid_o, dmem_req}, 32'd0);

    // Random operations against the rule-level model.
    op_pool = '{5'h00, 5'h01, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11, 5'h1F, 5'h0D};
    for (int n = 0; n < 40; n++) begin
      r_op = (n % 7 == 6) ? 5'($urandom) : op_pool[$urandom_range(0, 9)];
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_data = $urandom;
      r_rdata = $urandom;
      r_delay = $urandom_range(0, 6);
      r_exp = model(r_op, r_addr, r_data, r_rdata, r_delay);
      run_op($sformatf("rand%0d", n), r_op, r_addr, r_data, r_delay, r_rdata, r_exp[32], r_exp[31:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
